// File: rtl/uart_program_loader_if.sv
// Main-memory write port of the UART program loader: request/address/data out, ready back.
interface uart_program_loader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ready_i;

  modport master (output mem_req_o, output mem_addr_o, output mem_wdata_o, input mem_ready_i);
  modport slave  (input mem_req_o, input mem_addr_o, input mem_wdata_o, output mem_ready_i);
endinterface

// File: rtl/uart_program_loader.sv
// Loads a framed program image from a UART line into memory; write issued 1 cycle after a word completes.
// One-word holding register; a word completing while it is still blocked is dropped (overrun). Option: LOADER_CHECKSUM_EN.
module uart_program_loader #(
  parameter int unsigned       BAUD_DIV  = 868,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned       LEN_W     = 16,
  parameter logic [7:0]        HDR_BYTE  = 8'hA5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 program_rx_i,
  output logic                 prog_mode_o,
  output logic                 core_rst_no,
  uart_program_loader_if.master mem,
  output logic                 err_o,
  output logic [LEN_W-1:0]     words_o
);
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned CNT_W  = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    L_IDLE, L_LEN0, L_LEN1, L_DATA,
`ifdef LOADER_CHECKSUM_EN
    L_CSUM,
`endif
    L_DRAIN
  } ld_state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t L_TAIL = L_CSUM;
`else
  localparam ld_state_t L_TAIL = L_DRAIN;
`endif

  // UART receiver
  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_sr, rx_byte;
  logic             rx_vld, rx_ferr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= program_rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state <= RX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      rx_sr    <= '0;
      rx_byte  <= '0;
      rx_vld   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          baud_cnt <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          // Half a bit in: a line back high here was a glitch, not a start bit.
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            rx_sr    <= {rx_sync, rx_sr[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              rx_vld  <= 1'b1;
              rx_byte <= rx_sr;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Frame loader
  ld_state_t         ld_state;
  logic              boot_done;
  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  words_left;
  logic [LEN_W-1:0]  len_rx;
  logic [BCNT_W-1:0] byte_cnt;
  logic [DATA_W-1:0] word_sr, word_next;
  logic [ADDR_W-1:0] next_addr, hold_addr;
  logic [DATA_W-1:0] hold_dat;
  logic              hold_vld;
  logic [7:0]        csum;
  logic              overrun, csum_bad, err_set, handshake;

  assign word_next = DATA_W'({rx_byte, word_sr} >> 8);
  assign len_rx    = LEN_W'({rx_byte, len_lo});
  assign handshake = hold_vld && mem.mem_ready_i;

  always_comb begin
    overrun  = (ld_state == L_DATA) && rx_vld && (byte_cnt == LAST_BYTE) && hold_vld && !mem.mem_ready_i;
    csum_bad = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_bad = (ld_state == L_CSUM) && rx_vld && (rx_byte != csum);
`endif
    err_set  = rx_ferr || overrun || csum_bad;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_state    <= L_IDLE;
      prog_mode_o <= 1'b0;
      core_rst_no <= 1'b0;
      boot_done   <= 1'b0;
      err_o       <= 1'b0;
      words_o     <= '0;
      len_lo      <= '0;
      words_left  <= '0;
      byte_cnt    <= '0;
      word_sr     <= '0;
      next_addr   <= BASE_ADDR;
      hold_vld    <= 1'b0;
      hold_addr   <= '0;
      hold_dat    <= '0;
      csum        <= '0;
    end else begin
      if (handshake) begin
        hold_vld <= 1'b0;
        words_o  <= words_o + 1'b1;
      end
      if (err_set) err_o <= 1'b1;

      case (ld_state)
        L_IDLE: begin
          if (!boot_done) begin
            core_rst_no <= 1'b1;
            boot_done   <= 1'b1;
          end
          if (rx_vld && rx_byte == HDR_BYTE) begin
            ld_state    <= L_LEN0;
            prog_mode_o <= 1'b1;
            core_rst_no <= 1'b0;
            boot_done   <= 1'b1;
            err_o       <= 1'b0;
            words_o     <= '0;
            byte_cnt    <= '0;
            next_addr   <= BASE_ADDR;
            csum        <= '0;
          end
        end
        L_LEN0: begin
          if (rx_vld) begin
            len_lo   <= rx_byte;
            ld_state <= L_LEN1;
          end
        end
        L_LEN1: begin
          if (rx_vld) begin
            words_left <= len_rx;
            ld_state   <= (len_rx == '0) ? L_TAIL : L_DATA;
          end
        end
        L_DATA: begin
          if (rx_vld) begin
            csum    <= csum ^ rx_byte;
            word_sr <= word_next;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt   <= '0;
              next_addr  <= next_addr + ADDR_W'(BYTES);
              words_left <= words_left - 1'b1;
              // A word leaving this cycle frees the holding register for the new one.
              if (!hold_vld || mem.mem_ready_i) begin
                hold_vld  <= 1'b1;
                hold_addr <= next_addr;
                hold_dat  <= word_next;
              end
              if (words_left == LEN_W'(1)) ld_state <= L_TAIL;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        L_CSUM: begin
          if (rx_vld) ld_state <= L_DRAIN;
        end
`endif
        default: begin
          if (!hold_vld) begin
            ld_state    <= L_IDLE;
            prog_mode_o <= 1'b0;
            core_rst_no <= !(err_o || err_set);
          end
        end
      endcase
    end
  end

  assign mem.mem_req_o   = hold_vld;
  assign mem.mem_addr_o  = hold_addr;
  assign mem.mem_wdata_o = hold_dat;
endmodule
